dly_tap_seq: RTL

Multi-channel tap sequencer for the AIB I/O delay lines. It owns the NUM_CH tap codes that drive the programmable delay chains and accepts tap-change requests over a valid/ready port. It moves each channel's code to its target either in one jump or as a ramp of single-LSB steps. Every code change is followed by a settle interval, so downstream data and clock paths never see a multi-code step while in ramp mode.

---
 rtl/dly_ctrl_pkg.sv | 15 +
 rtl/dly_tap_ramp.sv | 107 ++++++++++
 rtl/dly_tap_seq.sv | 71 +++++++
 3 files changed

// File: rtl/dly_ctrl_pkg.sv
// Shared types and default parameters for the delay-line tap sequencer.
package dly_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    SETTLE
  } tap_state_e;

  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_TAP_W      = 8;
  localparam int DEF_SETTLE_CYC = 4;
  localparam int DEF_RESET_TAP  = 0;

endpackage

// File: rtl/dly_tap_ramp.sv
// Single-channel tap FSM: moves the code to a latched target by jump or
// unit-step ramp, holding SETTLE_CYC cycles after every code change.
module dly_tap_ramp
  import dly_ctrl_pkg::*;
#(
  parameter int TAP_W      = DEF_TAP_W,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int RESET_TAP  = DEF_RESET_TAP
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [TAP_W-1:0] i_tap,
  input  logic             i_jump,
  output logic             o_busy,
  output logic             o_done,
  output logic [TAP_W-1:0] o_tap
);

  localparam int               CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [TAP_W-1:0] RST_CODE = TAP_W'(RESET_TAP);

  tap_state_e       state_q, state_d;
  logic [TAP_W-1:0] cur_q, cur_d;
  logic [TAP_W-1:0] tgt_q, tgt_d;
  logic             jump_q, jump_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    jump_d  = jump_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_load) begin
          tgt_d   = i_tap;
          jump_d  = i_jump;
          busy_d  = 1'b1;
          state_d = STEP;
        end
      end
      STEP: begin
        if (cur_q == tgt_q) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          // Direction from magnitude compare, so the ramp can never wrap.
          if (jump_q)             cur_d = tgt_q;
          else if (tgt_q > cur_q) cur_d = cur_q + 1'b1;
          else                    cur_d = cur_q - 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          if (cur_q == tgt_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = STEP;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cur_q   <= RST_CODE;
      tgt_q   <= RST_CODE;
      jump_q  <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      jump_q  <= jump_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_tap  = cur_q;

endmodule

// File: rtl/dly_tap_seq.sv
// Multi-channel delay-line tap sequencer: request decode, ready mux,
// out-of-range error pulse and one dly_tap_ramp per channel.
module dly_tap_seq
  import dly_ctrl_pkg::*;
#(
  parameter int  NUM_CH     = DEF_NUM_CH,
  parameter int  TAP_W      = DEF_TAP_W,
  parameter int  SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int  RESET_TAP  = DEF_RESET_TAP,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [CH_W-1:0]         i_req_ch,
  input  logic [TAP_W-1:0]        i_req_tap,
  input  logic                    i_req_jump,
  output logic [NUM_CH*TAP_W-1:0] o_tap,
  output logic [NUM_CH-1:0]       o_busy,
  output logic [NUM_CH-1:0]       o_done,
  output logic                    o_err
);

  localparam logic [CH_W:0] NUM_CH_L = NUM_CH[CH_W:0];

  logic [(2**CH_W)-1:0] busy_pad;
  logic [NUM_CH-1:0]    load;
  logic                 ch_oor;
  logic                 accept;
  logic                 err_q, err_d;

  assign ch_oor = ({1'b0, i_req_ch} >= NUM_CH_L);

  // Padded so an out-of-range channel index never selects past the bus.
  always_comb begin
    busy_pad             = '0;
    busy_pad[NUM_CH-1:0] = o_busy;
  end

  assign o_req_ready = ch_oor | ~busy_pad[i_req_ch];
  assign accept      = i_req_valid & o_req_ready;
  assign err_d       = accept & ch_oor;

  always_ff @(posedge i_clk) begin
    if (i_rst) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign o_err = err_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign load[k] = accept & ~ch_oor & (i_req_ch == CH_W'(k));

    dly_tap_ramp #(
      .TAP_W      (TAP_W),
      .SETTLE_CYC (SETTLE_CYC),
      .RESET_TAP  (RESET_TAP)
    ) u_ramp (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_load (load[k]),
      .i_tap  (i_req_tap),
      .i_jump (i_req_jump),
      .o_busy (o_busy[k]),
      .o_done (o_done[k]),
      .o_tap  (o_tap[k*TAP_W +: TAP_W])
    );
  end

endmodule
